mux16_scan_ctrl: RTL

Upstream sequencer for the `mux_16_1` 16:1 multiplexer. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data bus. It then steps the mux select through all 16 positions, one per accepted beat, and presents the mux output as a serial bit stream with valid/ready/last. The result is a parallel-to-serial converter built around the existing combinational mux.

---
 rtl/mux16_scan_ctrl_if.sv | 23 ++
 rtl/mux16_scan_ctrl.sv | 58 +++++
 2 files changed

// File: rtl/mux16_scan_ctrl_if.sv
// mux16_scan_ctrl_if: word input, mux drive/return and serial output bundle.
//   master: the scan controller side; slave: the upstream/mux/downstream side.
interface mux16_scan_ctrl_if;
  logic [15:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [15:0] mux_d;
  logic [3:0] mux_sel;
  logic mux_out;
  logic ser_bit;
  logic ser_valid;
  logic ser_ready;
  logic ser_last;
  logic err;
  modport master (
    input in_data, in_valid, mux_out, ser_ready,
    output in_ready, mux_d, mux_sel, ser_bit, ser_valid, ser_last, err
  );
  modport slave (
    output in_data, in_valid, mux_out, ser_ready,
    input in_ready, mux_d, mux_sel, ser_bit, ser_valid, ser_last, err
  );
endinterface

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: loads a 16-bit word onto a 16:1 mux and sweeps its select to serialize the word.
//   clk, rst       : clock, synchronous active-high reset
//   bus.in_*       : word input handshake (in_data, in_valid, in_ready)
//   bus.mux_*      : registered mux drive (mux_d, mux_sel) and combinational return (mux_out)
//   bus.ser_*      : serial output handshake (ser_bit, ser_valid, ser_ready, ser_last)
//   bus.err        : sticky loopback mismatch, only live with MUX_SCAN_CHECK_EN defined
//   MSB_FIRST      : 0 sweeps select 0..15, 1 sweeps 15..0
module mux16_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst,
  mux16_scan_ctrl_if.master bus
);
  localparam logic [3:0] first_sel = MSB_FIRST ? 4'hf : 4'h0;
  localparam logic [3:0] last_sel = MSB_FIRST ? 4'h0 : 4'hf;
  typedef enum logic {idle, scan} state_t;
  state_t state, next_state;
  logic [15:0] d;
  logic [3:0] sel;
  logic load, beat, last;
  always_ff @(posedge clk)
    state <= rst ? idle : next_state;
  always_comb begin
    load = (state == idle) && bus.in_valid;
    beat = (state == scan) && bus.ser_ready;
    last = (state == scan) && (sel == last_sel);
    next_state = load ? scan : (beat && last) ? idle : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      d <= 16'h0000;
      sel <= 4'h0;
    end else if (load) begin
      d <= bus.in_data;
      sel <= first_sel;
    end else if (beat && !last) begin
      sel <= MSB_FIRST ? sel - 4'd1 : sel + 4'd1;
    end
`ifdef MUX_SCAN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk)
    err_q <= rst ? 1'b0 : err_q | (beat && (bus.mux_out != d[sel]));
`endif
  always_comb begin
    bus.in_ready = (state == idle) && !rst;
    bus.ser_valid = state == scan;
    bus.ser_last = last;
    bus.ser_bit = bus.mux_out;
    bus.mux_d = d;
    bus.mux_sel = sel;
`ifdef MUX_SCAN_CHECK_EN
    bus.err = err_q;
`else
    bus.err = 1'b0;
`endif
  end
endmodule
